// File: rtl/priority_grant_decoder.sv
// Registered one-hot grant decoder with hold timeout (IDLE -> GRANT -> RELEASE).
// Optional macro PRIO_GRANT_STATS_EN adds a saturating 8-bit grant_count output.
module priority_grant_decoder #(
   parameter int HOLD_MAX = 15,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic [1:0] req_idx,
   output logic       req_ready,
   input  logic [3:0] done,
   output logic [3:0] grant,
`ifdef PRIO_GRANT_STATS_EN
   output logic [7:0] grant_count,
`endif
   output logic       timeout,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

   state_t           state;
   logic [1:0]       idx_q;
   logic [CNT_W-1:0] hold_cnt;

   // All outputs are registered so they settle with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx_q     <= 2'd0;
         hold_cnt  <= '0;
         grant     <= 4'b0000;
         timeout   <= 1'b0;
         busy      <= 1'b0;
         req_ready <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  state     <= GRANT;
                  idx_q     <= req_idx;
                  hold_cnt  <= '0;
                  grant     <= 4'b0001 << req_idx;
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            GRANT: begin
               // A release by the owner takes precedence over the hold limit.
               if (done[idx_q]) begin
                  state <= RELEASE;
                  grant <= 4'b0000;
               end else if (hold_cnt == HOLD_LIM) begin
                  state   <= RELEASE;
                  grant   <= 4'b0000;
                  timeout <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            RELEASE: begin
               state     <= IDLE;
               busy      <= 1'b0;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               grant     <= 4'b0000;
               busy      <= 1'b0;
               req_ready <= 1'b0;
            end
         endcase
      end
   end

`ifdef PRIO_GRANT_STATS_EN
   // Counts accepted requests only, saturating at the top of the 8-bit range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_count <= 8'd0;
      end else if (state == IDLE && req_valid && req_ready && grant_count != 8'd255) begin
         grant_count <= grant_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_priority_grant_decoder.sv
// Directed self-checking bench for priority_grant_decoder (HOLD_MAX=15).
// Exercises the PRIO_GRANT_STATS_EN counter only when that macro is defined.
module tb_priority_grant_decoder;

   logic       clk;
   logic       rst_n;
   logic       req_valid;
   logic [1:0] req_idx;
   logic       req_ready;
   logic [3:0] done;
   logic [3:0] grant;
   logic       timeout;
   logic       busy;
`ifdef PRIO_GRANT_STATS_EN
   logic [7:0] grant_count;
`endif

   int tests_run;
   int tests_failed;

   priority_grant_decoder #(.HOLD_MAX(15), .CNT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_idx    (req_idx),
      .req_ready  (req_ready),
      .done       (done),
      .grant      (grant),
`ifdef PRIO_GRANT_STATS_EN
      .grant_count(grant_count),
`endif
      .timeout    (timeout),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_idx = 2'd0; done = 4'b0000;
      tick();
      tests_run++;
      if ({grant, timeout, busy, req_ready} !== 7'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got %b, expected 0000000", {grant, timeout, busy, req_ready});
      end
      rst_n = 1'b1;
      #1;
      tests_run++;
      if (req_ready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL ready_before_edge: got %b, expected 0", req_ready);
      end
      tick();
      tests_run++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL ready_after_edge: got ready=%b busy=%b, expected ready=1 busy=0", req_ready, busy);
      end
   endtask

   task automatic test_grant_and_release();
      done = 4'b1111;
      tick();
      done = 4'b0000;
      tests_run++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || grant !== 4'b0000) begin
         tests_failed++;
         $display("[TB] FAIL idle_done_ignored: got ready=%b busy=%b grant=%b", req_ready, busy, grant);
      end
      req_valid = 1'b1; req_idx = 2'd2;
      tick();
      req_valid = 1'b0;
      tests_run++;
      if (grant !== 4'b0100 || busy !== 1'b1 || req_ready !== 1'b0 || timeout !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL grant_idx2: got grant=%b busy=%b ready=%b, expected 0100 1 0", grant, busy, req_ready);
      end
      done = 4'b1011;
      tick();
      done = 4'b0000;
      tests_run++;
      if (grant !== 4'b0100) begin
         tests_failed++;
         $display("[TB] FAIL other_done_ignored: got grant=%b, expected 0100", grant);
      end
      req_valid = 1'b1; req_idx = 2'd3;
      tick();
      req_valid = 1'b0;
      tests_run++;
      if (grant !== 4'b0100 || req_ready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL req_dropped: got grant=%b ready=%b, expected 0100 0", grant, req_ready);
      end
      done = 4'b0100;
      tick();
      done = 4'b0000;
      tests_run++;
      if (grant !== 4'b0000 || timeout !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL release_cycle: got grant=%b timeout=%b ready=%b busy=%b, expected 0000 0 0 1", grant, timeout, req_ready, busy);
      end
      tick();
      tests_run++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || timeout !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL back_to_idle: got ready=%b busy=%b timeout=%b, expected 1 0 0", req_ready, busy, timeout);
      end
   endtask

   task automatic test_timeout();
      int held_bad;
      held_bad = 0;
      req_valid = 1'b1; req_idx = 2'd1;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (grant !== 4'b0010 || timeout !== 1'b0) held_bad++;
         tick();
      end
      tests_run++;
      if (held_bad != 0 || grant !== 4'b0010 || timeout !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_hold: got %0d bad cycles, grant=%b timeout=%b, expected 0 0010 0", held_bad, grant, timeout);
      end
      tick();
      tests_run++;
      if (timeout !== 1'b1 || grant !== 4'b0000) begin
         tests_failed++;
         $display("[TB] FAIL timeout_pulse: got timeout=%b grant=%b, expected 1 0000", timeout, grant);
      end
      tick();
      tests_run++;
      if (timeout !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_one_cycle: got timeout=%b ready=%b busy=%b, expected 0 1 0", timeout, req_ready, busy);
      end
   endtask

   task automatic test_done_at_limit();
      req_valid = 1'b1; req_idx = 2'd3;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      tests_run++;
      if (grant !== 4'b1000 || timeout !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL at_limit_hold: got grant=%b timeout=%b, expected 1000 0", grant, timeout);
      end
      done = 4'b1000;
      tick();
      done = 4'b0000;
      tests_run++;
      if (grant !== 4'b0000 || timeout !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL done_wins: got grant=%b timeout=%b, expected 0000 0", grant, timeout);
      end
      tick();
      tests_run++;
      if (req_ready !== 1'b1 || timeout !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL done_wins_idle: got ready=%b timeout=%b, expected 1 0", req_ready, timeout);
      end
   endtask

   task automatic test_reset_mid_grant();
      req_valid = 1'b1; req_idx = 2'd1;
      tick();
      req_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (grant !== 4'b0000 || req_ready !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL async_reset: got grant=%b ready=%b busy=%b timeout=%b, expected 0000 0 0 0", grant, req_ready, busy, timeout);
      end
      tick();
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (req_ready !== 1'b1 || timeout !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL ready_after_reset: got ready=%b timeout=%b, expected 1 0", req_ready, timeout);
      end
      req_valid = 1'b1; req_idx = 2'd0;
      tick();
      req_valid = 1'b0;
      tests_run++;
      if (grant !== 4'b0001) begin
         tests_failed++;
         $display("[TB] FAIL grant_idx0: got grant=%b, expected 0001", grant);
      end
      done = 4'b0001;
      tick();
      done = 4'b0000;
      tick();
      tests_run++;
      if (req_ready !== 1'b1 || grant !== 4'b0000) begin
         tests_failed++;
         $display("[TB] FAIL idx0_release: got ready=%b grant=%b, expected 1 0000", req_ready, grant);
      end
   endtask

`ifdef PRIO_GRANT_STATS_EN
   task automatic test_back_to_back();
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (grant_count !== 8'd0) begin
         tests_failed++;
         $display("[TB] FAIL count_reset: got %0d, expected 0", grant_count);
      end
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 300; i++) begin
         req_valid = 1'b1; req_idx = 2'(i % 4);
         tick();
         req_valid = 1'b0;
         done = 4'b1111;
         tick();
         done = 4'b0000;
         tick();
         if (i == 9) begin
            tests_run++;
            if (grant_count !== 8'd10) begin
               tests_failed++;
               $display("[TB] FAIL count_10: got %0d, expected 10", grant_count);
            end
         end
      end
      tests_run++;
      if (grant_count !== 8'd255) begin
         tests_failed++;
         $display("[TB] FAIL count_saturate: got %0d, expected 255", grant_count);
      end
   endtask
`endif

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_grant_and_release();
      test_timeout();
      test_done_at_limit();
      test_reset_mid_grant();
`ifdef PRIO_GRANT_STATS_EN
      test_back_to_back();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
